bcd_time_loader: RTL and testbench

Time-set entry block for the digital clock. It accepts a stream of BCD digits (HH MM SS, most significant first) over a valid/ready handshake and range-checks the assembled time. It converts each digit pair to 6-bit binary and issues a one-cycle load pulse with binary hour/minute/second values for the timekeeping counters. It is the inverse path of the binary-to-BCD display conversion: user/keypad digits in, binary counter preload out.

---
 rtl/bcd_time_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_bcd_time_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_loader.sv
// -----------------------------------------------------------------------------
// bcd_time_loader
//
// Time-set entry for the digital clock. BCD digits arrive most significant
// first (HH MM SS) over a valid/ready handshake. Once all digits are held, the
// block converts each pair to binary and range-checks the time. A legal time
// is presented on hour/minute/second together with a one-cycle load strobe.
// An illegal digit, an out-of-range time or an inter-digit timeout produces a
// one-cycle error strobe instead.
//
// Optional feature macro: BCD_LOADER_AMPM_EN
//   Defined: 12-hour entry with a seventh digit as the AM/PM flag (0=AM, 1=PM).
//            Legal hours are 01..12 and are converted to 24-hour binary.
//            HOUR_MAX is ignored.
//   Undefined: six-digit 24-hour entry, hour legal up to HOUR_MAX.
//
// Parameters
//   HOUR_MAX        largest legal hour in 24-hour mode
//   TIMEOUT_CYCLES  idle cycles allowed between digits, 0 disables the timeout
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   digit_valid  in   digit offered
//   digit        in   BCD digit
//   digit_ready  out  block can accept a digit
//   cancel       in   synchronous abort of the current entry
//   hour         out  loaded hour, binary
//   minute       out  loaded minute, binary
//   second       out  loaded second, binary
//   load         out  one-cycle strobe, hour/minute/second are new
//   error        out  one-cycle strobe, entry rejected
//   busy         out  entry in progress
//   digit_count  out  digits accepted in the current entry
// -----------------------------------------------------------------------------
module bcd_time_loader #(
    parameter int HOUR_MAX       = 23,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic       digit_ready,
    input  logic       cancel,
    output logic [5:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       load,
    output logic       error,
    output logic       busy,
    output logic [2:0] digit_count
);

`ifdef BCD_LOADER_AMPM_EN
    localparam logic [2:0] LAST_POS = 3'd6;
`else
    localparam logic [2:0] LAST_POS = 3'd5;
`endif
    localparam int            TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] IDLE_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK
    } state_t;

    state_t        state_q;
    logic [2:0]    count_q;
    logic [TW-1:0] idle_q;
    logic          ready_q;
    logic          busy_q;
    logic          load_q;
    logic          error_q;
    logic [5:0]    hour_q;
    logic [5:0]    minute_q;
    logic [5:0]    second_q;

    // Digit storage, by position. Pure data, so no reset.
    logic [3:0]    ht_q, ho_q, mt_q, mo_q, st_q, so_q;
`ifdef BCD_LOADER_AMPM_EN
    logic          pm_q;
`endif

    logic          accept;
    logic          digit_ok;
    logic          hour_ok;
    logic          time_ok;
    logic [6:0]    hr_bin, mn_bin, sc_bin, hr_load;

    // tens*10 + ones as (tens<<3) + (tens<<1) + ones; 99 fits in 7 bits.
    function automatic logic [6:0] bcd_pair(input logic [3:0] tens, input logic [3:0] ones);
        logic [6:0] t;
        t = {3'b000, tens};
        return (t << 3) + (t << 1) + {3'b000, ones};
    endfunction

    assign accept = digit_valid && ready_q;

    always_comb begin
        digit_ok = (digit <= 4'd9);
`ifdef BCD_LOADER_AMPM_EN
        // The AM/PM position only takes 0 or 1.
        if (count_q == LAST_POS) begin
            digit_ok = (digit <= 4'd1);
        end
`endif
    end

    always_comb begin
        hr_bin = bcd_pair(ht_q, ho_q);
        mn_bin = bcd_pair(mt_q, mo_q);
        sc_bin = bcd_pair(st_q, so_q);
`ifdef BCD_LOADER_AMPM_EN
        hour_ok = (hr_bin != 7'd0) && (hr_bin <= 7'd12);
        // 12 AM is midnight, 12 PM is noon; other PM hours shift by 12.
        if (pm_q) begin
            hr_load = (hr_bin == 7'd12) ? 7'd12 : hr_bin + 7'd12;
        end else begin
            hr_load = (hr_bin == 7'd12) ? 7'd0 : hr_bin;
        end
`else
        hour_ok = (32'(hr_bin) <= HOUR_MAX);
        hr_load = hr_bin;
`endif
        time_ok = hour_ok && (mn_bin <= 7'd59) && (sc_bin <= 7'd59);
    end

    always_ff @(posedge clk) begin
        if (accept && !cancel && digit_ok) begin
            case (count_q)
                3'd0:    ht_q <= digit;
                3'd1:    ho_q <= digit;
                3'd2:    mt_q <= digit;
                3'd3:    mo_q <= digit;
                3'd4:    st_q <= digit;
                3'd5:    so_q <= digit;
`ifdef BCD_LOADER_AMPM_EN
                3'd6:    pm_q <= digit[0];
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            idle_q   <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            load_q   <= 1'b0;
            error_q  <= 1'b0;
            hour_q   <= '0;
            minute_q <= '0;
            second_q <= '0;
        end else begin
            load_q  <= 1'b0;
            error_q <= 1'b0;
            if (cancel) begin
                // Cancel beats a simultaneous accept; the digit is dropped.
                state_q <= S_IDLE;
                count_q <= '0;
                idle_q  <= '0;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_COLLECT: begin
                        if (accept) begin
                            idle_q <= '0;
                            if (!digit_ok) begin
                                error_q <= 1'b1;
                                state_q <= S_IDLE;
                                count_q <= '0;
                                busy_q  <= 1'b0;
                            end else if (count_q == LAST_POS) begin
                                state_q <= S_CHECK;
                                count_q <= count_q + 3'd1;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= S_COLLECT;
                                count_q <= count_q + 3'd1;
                                busy_q  <= 1'b1;
                            end
                        end else if (state_q == S_COLLECT && TIMEOUT_CYCLES != 0) begin
                            if (idle_q == IDLE_LAST) begin
                                error_q <= 1'b1;
                                state_q <= S_IDLE;
                                count_q <= '0;
                                idle_q  <= '0;
                                busy_q  <= 1'b0;
                            end else begin
                                idle_q <= idle_q + 1'b1;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (time_ok) begin
                            load_q   <= 1'b1;
                            hour_q   <= hr_load[5:0];
                            minute_q <= mn_bin[5:0];
                            second_q <= sc_bin[5:0];
                        end else begin
                            error_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                        count_q <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        count_q <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign digit_ready = ready_q;
    assign busy        = busy_q;
    assign load        = load_q;
    assign error       = error_q;
    assign hour        = hour_q;
    assign minute      = minute_q;
    assign second      = second_q;
    assign digit_count = count_q;

endmodule

// File: tb/tb_bcd_time_loader.sv
module tb_bcd_time_loader;

    localparam int TO = 8;
`ifdef BCD_LOADER_AMPM_EN
    localparam int NDIG = 7;
`else
    localparam int NDIG = 6;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       cancel = 1'b0;
    logic       digit_ready;
    logic [5:0] hour, minute, second;
    logic       load, error, busy;
    logic [2:0] digit_count;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    bcd_time_loader #(
        .HOUR_MAX      (23),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_valid(digit_valid),
        .digit      (digit),
        .digit_ready(digit_ready),
        .cancel     (cancel),
        .hour       (hour),
        .minute     (minute),
        .second     (second),
        .load       (load),
        .error      (error),
        .busy       (busy),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: the entry is a list of held digits; outputs follow
    // from the list length and the time rules applied with plain arithmetic.
    int q[$];
    bit checking;
    int idle;
    int e_hour, e_minute, e_second;
    bit e_load, e_err;

    always @(posedge clk or negedge rst_n) begin
        int h, m, s, h24;
        bit ok;
        e_load = 0;
        e_err  = 0;
        if (!rst_n) begin
            q.delete(); checking = 0; idle = 0;
            e_hour = 0; e_minute = 0; e_second = 0;
        end else if (cancel) begin
            q.delete(); checking = 0; idle = 0;
        end else if (checking) begin
            h = q[0] * 10 + q[1];
            m = q[2] * 10 + q[3];
            s = q[4] * 10 + q[5];
            if (NDIG == 7) begin
                ok = (h >= 1) && (h <= 12);
                if (q[6] == 1) h24 = (h == 12) ? 12 : h + 12;
                else           h24 = (h == 12) ? 0 : h;
            end else begin
                ok  = (h <= 23);
                h24 = h;
            end
            ok = ok && (m <= 59) && (s <= 59);
            if (ok) begin
                e_hour = h24; e_minute = m; e_second = s; e_load = 1;
            end else begin
                e_err = 1;
            end
            q.delete(); checking = 0;
        end else if (digit_valid) begin
            idle = 0;
            if (digit > 9 || (NDIG == 7 && q.size() == 6 && digit > 1)) begin
                e_err = 1; q.delete();
            end else begin
                q.push_back(int'(digit));
                if (q.size() == NDIG) checking = 1;
            end
        end else if (q.size() > 0) begin
            idle++;
            if (idle == TO) begin
                e_err = 1; q.delete(); idle = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("load",   load,        e_load);
            chk("error",  error,       e_err);
            chk("hour",   hour,        e_hour);
            chk("minute", minute,      e_minute);
            chk("second", second,      e_second);
            chk("count",  digit_count, q.size());
            chk("ready",  digit_ready, !checking);
            chk("busy",   busy,        q.size() > 0);
        end
    end

    task automatic send_seq(input int n, input int d[8]);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            digit_valid = 1'b1;
            digit = 4'(d[i]);
        end
        @(negedge clk);
        digit_valid = 1'b0;
    endtask

    initial begin
        int gap, p;
        gap = 0;
        repeat (3) @(negedge clk);
        chk("rst_hour", hour, 0);
        chk("rst_ready", digit_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", digit_count, 0);
        chk("rst_strobes", {load, error}, 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

`ifndef BCD_LOADER_AMPM_EN
        // 23:59:58 back-to-back
        send_seq(6, '{2, 3, 5, 9, 5, 8, 0, 0});
        chk("chk_ready_low", digit_ready, 0);
        @(negedge clk);
        chk("t1_load", load, 1);
        chk("t1_hms", {hour, minute, second}, {6'd23, 6'd59, 6'd58});
        chk("model_t1_hour", e_hour, 23);
        @(negedge clk);
        chk("t1_load_1cyc", load, 0);

        // 24:00:00 is out of range
        send_seq(6, '{2, 4, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        chk("t2_error", error, 1);
        chk("t2_load", load, 0);
        chk("t2_hms_kept", {hour, minute, second}, {6'd23, 6'd59, 6'd58});
        chk("t2_count", digit_count, 0);
        @(negedge clk);
        chk("t2_err_1cyc", error, 0);

        // bad digit 0xA
        send_seq(3, '{1, 2, 10, 0, 0, 0, 0, 0});
        chk("t3_error", error, 1);
        chk("t3_count", digit_count, 0);
        send_seq(6, '{0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        chk("t3_load0", load, 1);
        chk("t3_hms0", {hour, minute, second}, 18'd0);
        chk("model_t3_min", e_minute, 0);
`else
        send_seq(7, '{1, 2, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        chk("ap_12am_load", load, 1);
        chk("ap_12am_hour", hour, 0);
        send_seq(7, '{1, 2, 3, 0, 0, 0, 1, 0});
        @(negedge clk);
        chk("ap_12pm_hm", {hour, minute}, {6'd12, 6'd30});
        chk("model_ap_hour", e_hour, 12);
        send_seq(7, '{0, 7, 0, 0, 0, 0, 1, 0});
        @(negedge clk);
        chk("ap_7pm_hour", hour, 19);
        send_seq(7, '{0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        chk("ap_00_error", error, 1);
        chk("ap_00_kept", hour, 19);
        send_seq(7, '{0, 1, 0, 0, 0, 0, 2, 0});
        chk("ap_flag_error", error, 1);
`endif

        // cancel together with an offered digit
        send_seq(3, '{1, 1, 1, 0, 0, 0, 0, 0});
        chk("t4_count3", digit_count, 3);
        cancel = 1'b1; digit_valid = 1'b1; digit = 4'd5;
        @(negedge clk);
        cancel = 1'b0; digit_valid = 1'b0;
        chk("t4_count0", digit_count, 0);
        chk("t4_nostrobe", {load, error}, 0);
        chk("t4_busy", busy, 0);
        @(negedge clk);
        chk("t4_nostrobe2", {load, error}, 0);

        // load a non-zero time, then reset mid-entry
        send_seq(NDIG, '{1, 1, 3, 4, 5, 6, 0, 0});
        @(negedge clk);
        chk("t5_min", minute, 34);
        send_seq(4, '{1, 2, 3, 4, 0, 0, 0, 0});
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_hms", {hour, minute, second}, 18'd0);
        chk("t5_rst_count", digit_count, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", digit_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // timeout after 8 idle edges
        send_seq(2, '{1, 2, 0, 0, 0, 0, 0, 0});
        repeat (7) @(negedge clk);
        chk("t6_no_err_yet", error, 0);
        chk("t6_count2", digit_count, 2);
        @(negedge clk);
        chk("t6_timeout_err", error, 1);
        chk("t6_count0", digit_count, 0);

        // 7 idle edges then a digit: no timeout
        send_seq(2, '{1, 2, 0, 0, 0, 0, 0, 0});
        repeat (7) @(negedge clk);
        digit_valid = 1'b1; digit = 4'd3;
        @(negedge clk);
        digit_valid = 1'b0;
        chk("t7_no_err", error, 0);
        chk("t7_count3", digit_count, 3);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            cancel = ($urandom_range(0, 199) == 0);
            if (gap > 0) begin
                digit_valid = 1'b0;
                gap--;
            end else begin
                digit_valid = ($urandom_range(0, 99) < 75);
                if ($urandom_range(0, 39) == 0) gap = $urandom_range(4, 12);
                p = $urandom_range(0, 99);
                if (p < 4)       digit = 4'($urandom_range(10, 15));
                else if (p < 60) digit = 4'($urandom_range(0, 2));
                else             digit = 4'($urandom_range(0, 9));
            end
        end
        @(negedge clk);
        digit_valid = 1'b0;
        cancel = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
